// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop-It game sequencer.
package stop_it_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        CHECK = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_e;

    localparam int unsigned MAX_LEVEL = 3;
    localparam logic [15:0] ALL_ON    = 16'hFFFF;

endpackage

// File: rtl/stop_it_rise_detect.sv
// Registered rising-edge detector; history resets high so a button held through reset is not an edge.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic rise_o
);

    logic btn_d, btn_q;

    assign btn_d = btn_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) btn_q <= 1'b1;
        else         btn_q <= btn_d;
    end

    assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/stop_it_ctrl.sv
// Stop-It game sequencer: paces shifts of the LED shifter, judges the stop press, keeps score.
module stop_it_ctrl
    import stop_it_pkg::*;
#(
    parameter int unsigned TICK_CYCLES   = 50_000_000,
    parameter int unsigned RESULT_CYCLES = 100_000_000,
    parameter logic [15:0] TARGET        = 16'h00FF,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               load_i,
    input  logic [15:0]        leds_i,
    output logic               shift_o,
    output logic               load_o,
    output logic               off_o,
    output logic               win_o,
    output logic               lose_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [2:0]         state_o
);

    localparam int unsigned MAX_CYC = (TICK_CYCLES > RESULT_CYCLES) ? TICK_CYCLES : RESULT_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] TICK_M1_0 = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_M1_1 = CNT_W'((TICK_CYCLES >> 1) - 1);
    localparam logic [CNT_W-1:0] TICK_M1_2 = CNT_W'((TICK_CYCLES >> 2) - 1);
    localparam logic [CNT_W-1:0] TICK_M1_3 = CNT_W'((TICK_CYCLES >> 3) - 1);
    localparam logic [CNT_W-1:0] RESULT_M1 = CNT_W'(RESULT_CYCLES - 1);

    logic start_rise, stop_rise, load_rise;

    rise_detect u_start (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(start_i), .rise_o(start_rise));
    rise_detect u_stop  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(stop_i),  .rise_o(stop_rise));
    rise_detect u_load  (.clk_i(clk_i), .rst_ni(rst_ni), .btn_i(load_i),  .rise_o(load_rise));

    state_e             state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [SCORE_W-1:0] score_d, score_q;
    logic [1:0]         level_d, level_q;
    logic               shift_d, shift_q;
    logic               load_d, load_q;
    logic               off_d, off_q;
    logic [CNT_W-1:0]   tick_m1;

    // Each level halves the shift period.
    always_comb begin
        case (level_q)
            2'd0:    tick_m1 = TICK_M1_0;
            2'd1:    tick_m1 = TICK_M1_1;
            2'd2:    tick_m1 = TICK_M1_2;
            default: tick_m1 = TICK_M1_3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        level_d = level_q;
        shift_d = 1'b0;
        load_d  = 1'b0;
        off_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_rise) begin
                    off_d   = 1'b1;
                    state_d = RUN;
                end else if (load_rise) begin
                    load_d = 1'b1;
                end
            end
            RUN: begin
                // Stop beats a coincident wrap so CHECK sees the pre-shift pattern.
                if (stop_rise) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end else if (cnt_q == tick_m1) begin
                    cnt_d = '0;
                    if (leds_i == ALL_ON) state_d = LOSE;
                    else                  shift_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (leds_i == TARGET) begin
                    state_d = WIN;
                    if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
                    level_d = (32'(score_d) >= MAX_LEVEL) ? 2'(MAX_LEVEL) : 2'(32'(score_d));
                end else begin
                    state_d = LOSE;
                end
            end
            WIN, LOSE: begin
                if (cnt_q == RESULT_M1) begin
                    cnt_d   = '0;
                    off_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            score_q <= '0;
            level_q <= '0;
            shift_q <= 1'b0;
            load_q  <= 1'b0;
            off_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
            level_q <= level_d;
            shift_q <= shift_d;
            load_q  <= load_d;
            off_q   <= off_d;
        end
    end

    assign shift_o = shift_q;
    assign load_o  = load_q;
    assign off_o   = off_q;
    assign win_o   = (state_q == WIN);
    assign lose_o  = (state_q == LOSE);
    assign score_o = score_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Directed bench for stop_it_ctrl with a behavioural LED shifter closing the loop.
module tb_stop_it_ctrl;

    localparam logic [15:0] TGT = 16'h0007;
    localparam logic [15:0] SW  = 16'h1234;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, load;
    logic [15:0] leds;
    logic        shift_o, load_o, off_o, win_o, lose_o;
    logic [7:0]  score_o;
    logic [2:0]  state_o;

    int n_vec = 0;
    int n_err = 0;

    stop_it_ctrl #(
        .TICK_CYCLES(8), .RESULT_CYCLES(4), .TARGET(TGT), .SCORE_W(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .load_i(load),
        .leds_i(leds), .shift_o(shift_o), .load_o(load_o), .off_o(off_o),
        .win_o(win_o), .lose_o(lose_o), .score_o(score_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Shifter model: clear, load switches, or shift a 1 in from the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       leds <= '0;
        else if (off_o)   leds <= '0;
        else if (load_o)  leds <= SW;
        else if (shift_o) leds <= {leds[14:0], 1'b1};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_shift(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!shift_o && cyc < 64);
        check("shift_seen", 32'(shift_o), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (state_o != 3'd0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(state_o), 0);
        check({tag, "_off"}, 32'(off_o), 1);
    endtask

    initial begin
        int c;
        int nsh;
        rst_n = 1'b0; start = 1'b1; stop = 1'b0; load = 1'b0;
        #12;
        check("rst_state", 32'(state_o), 0);
        check("rst_pulses", {29'd0, shift_o, load_o, off_o}, 0);
        check("rst_winlose", {30'd0, win_o, lose_o}, 0);
        check("rst_score", 32'(score_o), 0);

        // Start held across reset release: no edge.
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_start_off", 32'(off_o), 0);
        check("held_start_state", 32'(state_o), 0);

        start = 1'b0;
        @(negedge clk); load = 1'b1;
        @(negedge clk); check("idle_load", 32'(load_o), 1);
        load = 1'b0;
        @(negedge clk); check("idle_load_1cyc", 32'(load_o), 0);
        check("leds_loaded", 32'(leds), 32'(SW));

        // Game 1: level 0, period 8, stop on target -> WIN.
        start = 1'b1;
        @(negedge clk); check("g1_off", 32'(off_o), 1); check("g1_run", 32'(state_o), 1);
        @(negedge clk); check("g1_off_1cyc", 32'(off_o), 0); check("g1_leds_clr", 32'(leds), 0);
        wait_shift(c); check("g1_first_shift", c, 7);
        wait_shift(c); check("g1_period_a", c, 8);
        wait_shift(c); check("g1_period_b", c, 8);
        @(negedge clk); check("g1_leds", 32'(leds), 32'(TGT));
        stop = 1'b1;
        @(negedge clk); check("g1_check", 32'(state_o), 2);
        @(negedge clk); check("g1_win", 32'(state_o), 3);
        check("g1_win_o", 32'(win_o), 1); check("g1_score", 32'(score_o), 1);
        stop = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("g1_still_win", 32'(state_o), 3); check("g1_no_off_yet", 32'(off_o), 0);
        @(negedge clk); check("g1_end_off", 32'(off_o), 1); check("g1_end_idle", 32'(state_o), 0);

        // Game 2: level 1, period 4, stop at 0x0003 -> LOSE.
        @(negedge clk); start = 1'b1;
        @(negedge clk); check("g2_off", 32'(off_o), 1);
        wait_shift(c); check("g2_period_a", c, 4);
        wait_shift(c); check("g2_period_b", c, 4);
        @(negedge clk); check("g2_leds", 32'(leds), 3);
        stop = 1'b1;
        @(negedge clk); check("g2_check", 32'(state_o), 2);
        @(negedge clk); check("g2_lose", 32'(state_o), 4);
        check("g2_lose_o", 32'(lose_o), 1); check("g2_score", 32'(score_o), 1);
        stop = 1'b0; start = 1'b0;
        wait_idle("g2_idle");

        // Game 3: no stop -> 16 shifts, then overflow LOSE without a 17th.
        @(negedge clk); start = 1'b1;
        @(negedge clk); check("g3_off", 32'(off_o), 1);
        nsh = 0;
        for (int i = 0; i < 120 && state_o != 3'd4; i++) begin
            @(negedge clk);
            if (shift_o) nsh++;
        end
        check("g3_lose", 32'(state_o), 4);
        check("g3_shifts", nsh, 16);
        check("g3_leds", 32'(leds), 32'hFFFF);
        check("g3_no_shift", 32'(shift_o), 0);
        start = 1'b0;
        wait_idle("g3_idle");

        // Game 4: stop edge lands on the wrap cycle that would shift 0x0007 to 0x000F.
        @(negedge clk); start = 1'b1;
        @(negedge clk); check("g4_off", 32'(off_o), 1);
        nsh = 0;
        repeat (15) begin
            @(negedge clk);
            if (shift_o) nsh++;
        end
        check("g4_shifts", nsh, 3);
        check("g4_leds_pre", 32'(leds), 32'(TGT));
        stop = 1'b1;
        @(negedge clk); check("g4_check", 32'(state_o), 2); check("g4_no_shift", 32'(shift_o), 0);
        @(negedge clk); check("g4_win", 32'(state_o), 3); check("g4_score", 32'(score_o), 2);
        check("g4_leds_held", 32'(leds), 32'(TGT));

        // Reset asserted mid-WIN takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_win_state", 32'(state_o), 0);
        check("rst_win_outs", {27'd0, shift_o, load_o, off_o, win_o, lose_o}, 0);
        check("rst_win_score", 32'(score_o), 0);
        stop = 1'b0; start = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Coincident start and load edges in IDLE: start wins.
        @(negedge clk); start = 1'b1; load = 1'b1;
        @(negedge clk);
        check("sl_off", 32'(off_o), 1); check("sl_no_load", 32'(load_o), 0);
        check("sl_run", 32'(state_o), 1);
        load = 1'b0;
        @(negedge clk); load = 1'b1;
        @(negedge clk); check("run_load_ign", 32'(load_o), 0); check("run_stays", 32'(state_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
